add_seq_ctrl: RTL and testbench
===============================

// Module: add_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer for a 32-bit add built from one narrow adder slice.
//   Operands enter through a valid/ready handshake and are added SLICE_W bits per
//   cycle, least-significant slice first, with a registered carry between slices.
//   Trades latency for area; the result leaves through a valid/ready handshake.
// PARAMETERS
//   WIDTH    32  operand/result width; must be a multiple of SLICE_W
//   SLICE_W   4  bits added per cycle; NSLICE = WIDTH/SLICE_W (default 8)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   flush      in   1        synchronous abort; returns to IDLE, drops the operation
//   in_valid   in   1        operands a, b, cin valid
//   in_ready   out  1        block can accept operands (IDLE only)
//   a          in   WIDTH    operand A
//   b          in   WIDTH    operand B
//   cin        in   1        carry into slice 0
//   out_valid  out  1        sum valid; held until accepted
//   out_ready  in   1        consumer accepts the result
//   sum        out  WIDTH    A + B + cin, modulo 2^WIDTH
//   cout       out  1        carry out of MSB      (ADD_SEQ_FLAGS_EN only)
//   ovf        out  1        two's-complement ovf  (ADD_SEQ_FLAGS_EN only)
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0,
//     slice counter=0, carry reg=0, operand regs=0.
//   - FSM: IDLE -> RUN on in_valid&&in_ready (latch a, b; carry<=cin; cnt<=0).
//     RUN: each cycle add slice cnt (operand regs shift right by SLICE_W; the slice
//     sum shifts into the top of the sum reg); carry<=slice carry; cnt++.
//     RUN -> DONE when cnt==NSLICE-1 completes. DONE -> IDLE on out_ready.
//   - Latency: operands accepted at edge k -> out_valid=1 after edge k+NSLICE.
//   - in_ready=1 only in IDLE; no overlap between operations.
//     Minimum issue interval is NSLICE+1 cycles when out_ready is held high.
//   - out_valid=1 only in DONE; sum/cout/ovf are stable while out_valid=1.
//     sum is don't-care during RUN.
//   - Backpressure: out_ready=0 keeps DONE and holds all outputs indefinitely.
//   - flush=1 in any state: next state IDLE, cnt=0, out_valid=0. flush has priority over
//     an in_valid or out_ready handshake in the same cycle. The result is discarded.
//   - Reset asserted mid-RUN/DONE: immediate return to the reset values above.
//   - Wrap-around: the result is WIDTH bits; the carry out of the MSB is dropped
//     unless ADD_SEQ_FLAGS_EN is defined.
// CONFIGURATION
//   ADD_SEQ_FLAGS_EN defined: cout = carry after the last slice; ovf = (a[MSB]==b[MSB])
//     && (sum[MSB]!=a[MSB]), using the latched MSBs. Both are registered with sum.
//   ADD_SEQ_FLAGS_EN undefined: cout/ovf ports and their registers do not exist.
// STRUCTURE
//   - Shared header add_seq_defs.vh: state encodings S_IDLE=2'd0, S_RUN=2'd1,
//     S_DONE=2'd2; default WIDTH/SLICE_W constants.
//   - One sub-module: add_slice, a combinational SLICE_W-bit ripple adder
//     (a, b, ci -> s, co) built from full-adder cells.
//   - The FSM, counter, operand/sum shift registers and carry register live in add_seq_ctrl.
// TESTING
//   1 Reset: hold rst_n=0 -> in_ready=1, out_valid=0, sum=0; release -> IDLE.
//   2 a=32'h0000_0001, b=32'hFFFF_FFFF, cin=0 -> out_valid 8 cycles after accept,
//     sum=0, cout=1, ovf=0.
//   3 a=32'h7FFF_FFFF, b=1, cin=0; out_ready=0 for 5 cycles -> sum=32'h8000_0000, ovf=1
//     held stable all 5 cycles; accepted on the 6th; in_ready=1 next cycle.
//   4 flush on the 3rd RUN cycle (a=32'h1234_5678, b=32'h1111_1111) -> IDLE next cycle,
//     out_valid never asserts; a new op then gives its correct sum.
//   5 rst_n pulsed low mid-RUN -> outputs at reset values; the next op
//     (a=5, b=7, cin=1) -> sum=13.
//   6 Back-to-back ops with out_ready=1 and in_valid=1 -> in_ready low during RUN/DONE,
//     issue interval = 9 cycles, 100 random ops match A+B+cin.

Source files
------------

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the slice-serial adder sequencer.
//   - default operand width and slice width
//   - FSM state encoding (IDLE/RUN/DONE)
//   - counter-width helper
package add_seq_ctrl_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned SLICE_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE_W-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b  in   SLICE_W  slice operands
//   ci    in   1        carry in
//   s     out  SLICE_W  slice sum
//   co    out  1        carry out of the slice MSB
module add_slice
    import add_seq_ctrl_pkg::*;
#(
    parameter int unsigned SLICE_W = SLICE_W_DEF
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] c;

    assign c[0] = ci;

    // One full-adder cell per bit; carries ripple upward.
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[SLICE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// Slice-serial adder sequencer: computes a + b + cin over NSLICE cycles using a
// single SLICE_W-bit adder slice, least-significant slice first.
// Optional feature macro: ADD_SEQ_FLAGS_EN adds the cout and ovf outputs.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous abort back to IDLE, result dropped
//   in_valid/ready  operand handshake (ready only while IDLE)
//   a, b, cin       operands and carry into slice 0
//   out_valid/ready result handshake (valid only while DONE)
//   sum             a + b + cin modulo 2^WIDTH
//   cout, ovf       carry out / signed overflow (ADD_SEQ_FLAGS_EN only)
// WIDTH must be a multiple of SLICE_W and larger than SLICE_W.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned SLICE_W = SLICE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum
`ifdef ADD_SEQ_FLAGS_EN
    ,
    output logic             cout,
    output logic             ovf
`endif
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = cnt_width(NSLICE);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
`ifdef ADD_SEQ_FLAGS_EN
    logic               a_msb;
    logic               b_msb;
`endif

    // The adder always sees the lowest remaining slice of each operand.
    add_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a  (a_q[SLICE_W-1:0]),
        .b  (b_q[SLICE_W-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Sequencer FSM with registered handshake signals and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef ADD_SEQ_FLAGS_EN
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
`endif
        end else if (flush) begin
            // Abort wins over any handshake in the same cycle.
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_RUN;
`ifdef ADD_SEQ_FLAGS_EN
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    // Consume one slice: operands shift down, slice sum enters at the top.
                    a_q     <= a_q >> SLICE_W;
                    b_q     <= b_q >> SLICE_W;
                    sum     <= {slice_s, sum[WIDTH-1:SLICE_W]};
                    carry_q <= slice_co;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NSLICE - 1)) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
`ifdef ADD_SEQ_FLAGS_EN
                        // The final slice's MSB is the MSB of the full sum.
                        cout      <= slice_co;
                        ovf       <= (a_msb == b_msb) && (slice_s[SLICE_W-1] != a_msb);
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: directed corner cases plus random
// back-to-back operations checked against a plain-arithmetic reference.
module tb_add_seq_ctrl;

    localparam int unsigned NSLICE = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
`ifdef ADD_SEQ_FLAGS_EN
    logic        cout;
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    add_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
`ifdef ADD_SEQ_FLAGS_EN
        ,
        .cout      (cout),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full-precision addition, then truncate / derive flags.
    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic c);
        return {1'b0, x} + {1'b0, y} + {32'd0, c};
    endfunction

    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] s);
        return (x[31] == y[31]) && (s[31] != x[31]);
    endfunction

    // One complete operation: accept, measure latency, optional backpressure, retire.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input int stall);
        logic [32:0] exp;
        int          lat;
        int          ready_seen;
        int          unstable;
        exp = ref_add(ta, tb, tc);
        check({tag, "_ready_before"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0; ready_seen = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) ready_seen++;
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NSLICE));
        check({tag, "_ready_low_run"}, 32'(ready_seen), 32'd0);
        check({tag, "_sum"}, sum, exp[31:0]);
`ifdef ADD_SEQ_FLAGS_EN
        check({tag, "_cout"}, 32'(cout), 32'(exp[32]));
        check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(ta, tb, exp[31:0])));
`endif
        unstable = 0;
        for (int i = 0; i < stall; i++) begin
            step();
            if (out_valid !== 1'b1 || sum !== exp[31:0] || in_ready !== 1'b0) unstable++;
`ifdef ADD_SEQ_FLAGS_EN
            if (ovf !== ref_ovf(ta, tb, exp[31:0]) || cout !== exp[32]) unstable++;
`endif
        end
        if (stall > 0) check({tag, "_held"}, 32'(unstable), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_retired_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_retired_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [32:0] exp_q[$];
        logic [32:0] e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic        acc;
        int          issued;
        int          got;
        int          low_run;
        int          cyc;
        int          spurious;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        // Reset state
        step(); step(); step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", sum, 32'd0);
`ifdef ADD_SEQ_FLAGS_EN
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Wrap-around to zero with carry out
        do_op("wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);

        // Signed overflow under 5 cycles of backpressure
        do_op("ovf_stall", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5);

        // flush in the 3rd RUN cycle drops the operation
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
        end
        check("flush_quiet", 32'(spurious), 32'd0);

        // flush beats a simultaneous operand handshake
        a = 32'hDEAD_BEEF; b = 32'h0000_0001; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("flush_prio_ready", 32'(in_ready), 32'd1);
        do_op("after_flush", 32'h1234_5678, 32'h1111_1111, 1'b0, 0);

        // Async reset mid-RUN
        a = 32'hCAFE_F00D; b = 32'h0BAD_0BAD; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_sum", sum, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        do_op("after_rst", 32'd5, 32'd7, 1'b1, 0);

        // A few random single ops with random backpressure
        for (int i = 0; i < 6; i++) begin
            do_op("rand_single", $urandom, $urandom, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 4)));
        end

        // Back-to-back random ops, out_ready and in_valid held high
        out_ready = 1'b1;
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
        a = ra; b = rb; cin = rc; in_valid = 1'b1;
        issued = 0; got = 0; low_run = 0; cyc = 0;
        while (got < 100 && cyc < 3000) begin
            acc = in_ready && in_valid;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("b2b_sum", sum, e[31:0]);
                end
                got++;
            end
            if (in_ready !== 1'b1) begin
                low_run++;
            end else begin
                if (low_run != 0) check("b2b_busy_cycles", 32'(low_run), 32'(NSLICE + 1));
                low_run = 0;
            end
            if (acc) exp_q.push_back(ref_add(ra, rb, rc));
            step();
            cyc++;
            if (acc) begin
                issued++;
                ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
                a = ra; b = rb; cin = rc;
                if (issued == 100) in_valid = 1'b0;
            end
        end
        check("b2b_completed", 32'(got), 32'd100);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
